// File: rtl/button_event.sv
// Turns a debounced button level into press/release/short/long/repeat pulses.
// Optional feature macro: BUTTON_EVENT_REPEAT_EN enables auto-repeat while held long.
module button_event #(
  parameter int C_CLK_FRQ   = 100000000,
  parameter int C_LONG_MS   = 500,
  parameter int C_REPEAT_MS = 100
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       in,
  output logic       held,
  output logic       press,
  // release and repeat are reserved words, hence the _ev suffix on those two pulses
  output logic       release_ev,
  output logic       short,
  output logic       long,
  output logic       repeat_ev,
  output logic [1:0] dbg_state
);

  localparam int C_LONG_CYC = C_CLK_FRQ / 1000 * C_LONG_MS;
  localparam int C_REP_CYC  = C_CLK_FRQ / 1000 * C_REPEAT_MS;
  localparam int C_MAX_CYC  = (C_LONG_CYC > C_REP_CYC) ? C_LONG_CYC : C_REP_CYC;
  localparam int CNT_W      = $clog2(C_MAX_CYC + 1);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(C_LONG_CYC - 1);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_LONG    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             held_q, held_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;

`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(C_REP_CYC - 1);
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             repeat_q, repeat_d;
`endif

  // Release always takes priority over a threshold reached on the same edge.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    repeat_d   = 1'b0;
`endif
    case (state_q)
      ST_WAIT: begin
        if (!in) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (in) begin
          state_d    = ST_PRESSED;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      ST_PRESSED: begin
        if (!in) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d = ST_LONG;
          long_d  = 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
          rep_cnt_d = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      ST_LONG: begin
        if (!in) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
          if (rep_cnt_q == REP_LAST) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      default: state_d = ST_WAIT;
    endcase
    held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q    <= ST_WAIT;
      hold_cnt_q <= '0;
      held_q     <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      rep_cnt_q  <= '0;
      repeat_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      held_q     <= held_d;
      press_q    <= press_d;
      release_q  <= release_d;
      short_q    <= short_d;
      long_q     <= long_d;
`ifdef BUTTON_EVENT_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
      repeat_q   <= repeat_d;
`endif
    end
  end

  assign held       = held_q;
  assign press      = press_q;
  assign release_ev = release_q;
  assign short      = short_q;
  assign long       = long_q;
  assign dbg_state  = state_q;
`ifdef BUTTON_EVENT_REPEAT_EN
  assign repeat_ev  = repeat_q;
`else
  assign repeat_ev  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: per-cycle expected output vectors are queued as input is
// driven and compared one cycle later. Vector order {held,press,release,short,long,repeat}.
module tb_button_event;

  localparam int L = 50;
  localparam int R = 20;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       in = 1'b0;
  logic       held, press, release_ev, short, long, repeat_ev;
  logic [1:0] dbg_state;
  logic [5:0] obs;
  logic [5:0] exp_q[$];
  logic [5:0] exp_v;

  int total = 0;
  int bad = 0;

  button_event #(
    .C_CLK_FRQ  (10000),
    .C_LONG_MS  (5),
    .C_REPEAT_MS(2)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .in        (in),
    .held      (held),
    .press     (press),
    .release_ev(release_ev),
    .short     (short),
    .long      (long),
    .repeat_ev (repeat_ev),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  assign obs = {held, press, release_ev, short, long, repeat_ev};

  // Expected outputs at cycle t after a hold whose first sampled 1 is at edge 0 and
  // which lasts n sampled edges (edges 0..n-1 see in=1, edge n sees in=0).
  function automatic logic [5:0] exp_hold(input int n, input int t);
    logic h, p, rl, s, lg, rp;
    h  = (t >= 1) && (t <= n);
    p  = (t == 1);
    rl = (t == n + 1);
    s  = rl && (n <= L);
    lg = (t == L + 1) && (n > L);
    rp = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
    if ((n > L) && (t > L + 1) && (t <= n) && (((t - L - 1) % R) == 0)) rp = 1'b1;
`endif
    return {h, p, rl, s, lg, rp};
  endfunction

  task automatic drive_cycle(input logic in_v, input logic [5:0] e);
    in = in_v;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_hold(input string name, input int n, input int tail);
    for (int t = 0; t < n + tail; t++) begin
      drive_cycle(t < n, exp_hold(n, t + 1));
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL %s t=%0d: obs=%b exp=%b", name, t + 1, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 6'b0);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v || dbg_state !== 2'd0) begin
        bad++;
        $display("FAIL reset_hold i=%0d: obs=%b st=%0d exp=%b st=0", i, obs, dbg_state, exp_v);
      end
    end
    rstb = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b1, 6'b0);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL no_phantom i=%0d: obs=%b exp=%b", i, obs, exp_v);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 6'b0);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL wait_low i=%0d: obs=%b exp=%b", i, obs, exp_v);
      end
    end
    run_hold("first_press", 5, 3);
  endtask

  task automatic test_short();
    run_hold("short20", 20, 5);
    run_hold("short1", 1, 3);
    run_hold("short_rand", $urandom_range(2, 40), 4);
  endtask

  task automatic test_long();
    run_hold("long120", 120, 15);
  endtask

  task automatic test_boundary();
    run_hold("thresh_drop", L, 5);
    run_hold("thresh_plus1", L + 1, 5);
    run_hold("rep_edge_drop", L + R, 5);
    run_hold("rep_edge_plus1", L + R + 1, 5);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) run_hold("b2b", $urandom_range(1, 90), 2);
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 80; t++) begin
      drive_cycle(1'b1, exp_hold(1000, t + 1));
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL mid_hold t=%0d: obs=%b exp=%b", t + 1, obs, exp_v);
      end
    end
    rstb = 1'b0;
    drive_cycle(1'b1, 6'b0);
    exp_v = exp_q.pop_front();
    total++;
    if (obs !== exp_v || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset: obs=%b st=%0d exp=%b st=0", obs, dbg_state, exp_v);
    end
    rstb = 1'b1;
    for (int i = 0; i < 30; i++) begin
      drive_cycle(1'b1, 6'b0);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL post_reset_held i=%0d: obs=%b exp=%b", i, obs, exp_v);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 6'b0);
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL post_reset_low i=%0d: obs=%b exp=%b", i, obs, exp_v);
      end
    end
    run_hold("post_reset_press", 10, 3);
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_queue: size=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
